// File: rtl/keypad_scanner.sv
// keypad_scanner: walks the active-low columns of a 4x4 keypad, samples the synchronized rows,
// debounces whole-matrix scan results and reports committed presses as key_valid pulses.
module keypad_scanner #(
   parameter int DIV_BIT        = 14,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_down
);
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic {IDLE, PRESSED} state_t;

   typedef struct packed {
      logic       is_key;
      logic [3:0] code;
   } result_t;

   logic [3:0]         r_row_meta;
   logic [3:0]         r_row_sync;
   logic [DIV_BIT-1:0] r_div;
   logic [1:0]         r_col_sel;
   logic [3:0]         r_col;
   logic [3:0][3:0]    r_cap;      // [column][row], 1 = pressed
   logic [CNT_W-1:0]   r_cnt;
   result_t            r_prev;
   state_t             r_state;
   logic               r_key_valid;
   logic [3:0]         r_key_code;
   logic               r_key_down;

   logic [3:0]         w_row_s;
   logic               w_tick;
   logic               w_scan_done;
   logic [1:0]         w_col_sel_next;
   logic [15:0]        w_matrix;
   logic [4:0]         w_nset;
   logic [3:0]         w_code;
   result_t            w_result;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               w_commit;

   assign w_row_s        = ~r_row_sync;
   assign w_tick         = &r_div;
   assign w_scan_done    = w_tick && (r_col_sel == 2'd3);
   assign w_col_sel_next = r_col_sel + 2'd1;

   // Column 3 is sampled on the same tick that completes the scan, so it comes straight from w_row_s.
   always_comb begin
      w_matrix = '0;
      w_nset   = '0;
      w_code   = '0;
      w_result = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            w_matrix[r*4 + c] = (c == 3) ? w_row_s[r] : r_cap[c][r];
         end
      end
      for (int i = 0; i < 16; i++) begin
         if (w_matrix[i]) begin
            w_nset = w_nset + 5'd1;
            w_code = 4'(i);
         end
      end
      w_result.is_key = (w_nset == 5'd1);
      w_result.code   = w_result.is_key ? w_code : 4'd0;
   end

   always_comb begin
      w_cnt_next = CNT_W'(1);
      if (w_result == r_prev) begin
         w_cnt_next = (r_cnt >= CNT_W'(DEBOUNCE_SCANS)) ? CNT_W'(DEBOUNCE_SCANS)
                                                        : r_cnt + CNT_W'(1);
      end
   end

   assign w_commit = w_scan_done && (w_cnt_next == CNT_W'(DEBOUNCE_SCANS));

   // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_row_meta  <= 4'hF;
         r_row_sync  <= 4'hF;
         r_div       <= '0;
         r_col_sel   <= 2'd0;
         r_col       <= 4'b1110;
         r_cap       <= '0;
         r_cnt       <= '0;
         r_prev      <= '0;
         r_state     <= IDLE;
         r_key_valid <= 1'b0;
         r_key_code  <= 4'd0;
         r_key_down  <= 1'b0;
      end else begin
         r_row_meta  <= row;
         r_row_sync  <= r_row_meta;
         r_div       <= r_div + DIV_BIT'(1);
         r_key_valid <= 1'b0;

         if (w_tick) begin
            r_cap[r_col_sel] <= w_row_s;
            r_col_sel        <= w_col_sel_next;
            r_col            <= ~(4'b0001 << w_col_sel_next);
         end

         if (w_scan_done) begin
            r_cnt  <= w_cnt_next;
            r_prev <= w_result;
         end

         if (w_commit) begin
            case (r_state)
               IDLE: begin
                  if (w_result.is_key) begin
                     r_state     <= PRESSED;
                     r_key_code  <= w_result.code;
                     r_key_down  <= 1'b1;
                     r_key_valid <= 1'b1;
                  end
               end
               PRESSED: begin
                  if (!w_result.is_key) begin
                     r_state    <= IDLE;
                     r_key_down <= 1'b0;
                  end else if (w_result.code != r_key_code) begin
                     r_key_code  <= w_result.code;
                     r_key_valid <= 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign col       = r_col;
   assign key_valid = r_key_valid;
   assign key_code  = r_key_code;
   assign key_down  = r_key_down;
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model drives rows from col, a scoreboard
// queue holds expected key codes and a monitor pops one on every key_valid pulse.
module tb_keypad_scanner;
   localparam int SCAN = 16;   // clk cycles per full scan with DIV_BIT=2

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_down;
   logic [15:0] pressed;       // bit r*4+c = key (row r, col c) held

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_pulses = 0;
   logic [3:0]  exp_q[$];

   keypad_scanner #(.DIV_BIT(2), .DEBOUNCE_SCANS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row       (row),
      .col       (col),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_down  (key_down)
   );

   always #5 clk = ~clk;

   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4 + c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [7:0] actual, input logic [7:0] required);
      n_checks++;
      if (actual !== required) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, actual, required);
      end
   endtask

   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         n_pulses++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: got pulse with key_code %0d, required none", key_code);
         end else begin
            logic [3:0] exp_code;
            exp_code = exp_q.pop_front();
            check("pulse_key_code", {4'd0, key_code}, {4'd0, exp_code});
            check("pulse_key_down", {7'd0, key_down}, 8'd1);
         end
      end
   end

   task automatic drain(input string name, input int max_scans);
      int budget;
      budget = max_scans * SCAN + 8;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check(name, {7'd0, exp_q.size() == 0}, 8'd1);
      exp_q.delete();
   endtask

   task automatic wait_down(input string name, input logic level, input int max_scans);
      int budget;
      budget = max_scans * SCAN + 8;
      while (key_down !== level && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check(name, {7'd0, key_down}, {7'd0, level});
   endtask

   initial begin
      logic [3:0] col_tbl [5];
      int p0;
      col_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

      // 1: reset state and column walk
      rst_n   = 1'b0;
      pressed = 16'h0000;
      repeat (3) @(negedge clk);
      check("rst_col",       {4'd0, col}, 8'b1110);
      check("rst_key_valid", {7'd0, key_valid}, 8'd0);
      check("rst_key_down",  {7'd0, key_down}, 8'd0);
      check("rst_key_code",  {4'd0, key_code}, 8'd0);
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         check("col_walk", {4'd0, col}, {4'd0, col_tbl[k/4]});
      end

      // 2: hold (1,2) -> one pulse code 6, then silence
      exp_q.push_back(4'd6);
      pressed = 16'h0040;
      drain("press6_latency", 6);
      check("press6_key_down", {7'd0, key_down}, 8'd1);
      check("press6_key_code", {4'd0, key_code}, 8'd6);
      p0 = n_pulses;
      repeat (20 * SCAN) @(negedge clk);
      check("press6_no_repeat", 8'(n_pulses - p0), 8'd0);
      pressed = 16'h0000;
      wait_down("release6_key_down", 1'b0, 6);
      check("release6_key_code", {4'd0, key_code}, 8'd6);

      // 3: (3,3) bouncing every scan -> nothing commits
      p0 = n_pulses;
      for (int i = 0; i < 8; i++) begin
         pressed[15] = ~pressed[15];
         repeat (SCAN) @(negedge clk);
         check("bounce_key_down", {7'd0, key_down}, 8'd0);
      end
      pressed = 16'h0000;
      repeat (6 * SCAN) @(negedge clk);
      check("bounce_no_pulse", 8'(n_pulses - p0), 8'd0);

      // 4: (0,0)+(1,1) is ambiguous; releasing (0,0) leaves (1,1) -> code 5
      p0 = n_pulses;
      pressed = 16'h0021;
      repeat (8 * SCAN) @(negedge clk);
      check("ghost_no_pulse", 8'(n_pulses - p0), 8'd0);
      check("ghost_key_down", {7'd0, key_down}, 8'd0);
      exp_q.push_back(4'd5);
      pressed = 16'h0020;
      drain("press5_latency", 6);
      check("press5_key_down", {7'd0, key_down}, 8'd1);

      // 5: release, re-press same key, then roll over to (2,0)
      p0 = n_pulses;
      pressed = 16'h0000;
      wait_down("release5_key_down", 1'b0, 6);
      check("release5_no_pulse", 8'(n_pulses - p0), 8'd0);
      check("release5_key_code", {4'd0, key_code}, 8'd5);
      exp_q.push_back(4'd5);
      pressed = 16'h0020;
      drain("repress5_latency", 6);
      exp_q.push_back(4'd8);
      pressed = 16'h0100;
      drain("rollover8_latency", 6);
      check("rollover8_key_down", {7'd0, key_down}, 8'd1);
      check("rollover8_key_code", {4'd0, key_code}, 8'd8);

      // 6: reset while (0,3) held, then it is reported again
      exp_q.push_back(4'd3);
      pressed = 16'h0008;
      drain("rollover3_latency", 6);
      check("pre_reset_key_down", {7'd0, key_down}, 8'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_key_valid", {7'd0, key_valid}, 8'd0);
      check("midrst_key_down",  {7'd0, key_down}, 8'd0);
      check("midrst_key_code",  {4'd0, key_code}, 8'd0);
      check("midrst_col",       {4'd0, col}, 8'b1110);
      rst_n = 1'b1;
      exp_q.push_back(4'd3);
      drain("post_reset3_latency", 6);
      check("post_reset3_key_down", {7'd0, key_down}, 8'd1);
      repeat (2 * SCAN) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
